// File: rtl/imm_gen_pkg.sv
// rtl/imm_gen_pkg.sv - shared immediate-format codes used by the decoder and imm_gen
package imm_gen_pkg;

    typedef enum logic [2:0] {
        NO = 3'd0,
        RT = 3'd1,
        IT = 3'd2,
        ST = 3'd3,
        BT = 3'd4,
        UT = 3'd5,
        JT = 3'd6,
        CZ = 3'd7
    } imm_src_e;

    localparam int IMM_W = 32;

endpackage

// File: rtl/imm_gen_if.sv
// rtl/imm_gen_if.sv - handshake bus between the decoder, imm_gen and its consumer
interface imm_gen_if;
    import imm_gen_pkg::*;

    logic             i_flush;
    logic             i_valid;
    logic             o_ready;
    logic [31:0]      i_instr;
    logic [2:0]       i_ImmSrc;
    logic             o_valid;
    logic             i_ready;
    logic [IMM_W-1:0] o_imm;
    logic             o_err;

    modport slave (
        input  i_flush, i_valid, i_instr, i_ImmSrc, i_ready,
        output o_ready, o_valid, o_imm, o_err
    );

    modport master (
        output i_flush, i_valid, i_instr, i_ImmSrc, i_ready,
        input  o_ready, o_valid, o_imm, o_err
    );

endinterface

// File: rtl/imm_gen_ext.sv
// rtl/imm_gen_ext.sv - combinational immediate extraction; CZ decode under IMM_GEN_CSR_EN
module imm_gen_ext
    import imm_gen_pkg::*;
(
    input  logic [31:0]      i_instr,
    input  logic [2:0]       i_code,
    output logic [IMM_W-1:0] o_imm,
    output logic             o_err
);

    // Opcode bits never contribute to any immediate.
    logic w_unused_opcode;
    assign w_unused_opcode = ^i_instr[6:0];

    always_comb begin
        o_imm = '0;
        o_err = 1'b0;
        case (imm_src_e'(i_code))
            IT: o_imm = {{20{i_instr[31]}}, i_instr[31:20]};
            ST: o_imm = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            BT: o_imm = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                         i_instr[30:25], i_instr[11:8], 1'b0};
            UT: o_imm = {i_instr[31:12], 12'b0};
            JT: o_imm = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                         i_instr[20], i_instr[30:21], 1'b0};
`ifdef IMM_GEN_CSR_EN
            CZ: o_imm = {27'b0, i_instr[19:15]};
`endif
            default: begin
                o_imm = '0;
                o_err = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen.sv
// rtl/imm_gen.sv - immediate generator with output register plus skid buffer (IMM_GEN_CSR_EN in imm_gen_ext)
module imm_gen
    import imm_gen_pkg::*;
(
    input  logic     i_clk,
    input  logic     i_rst,
    imm_gen_if.slave bus
);

    logic [IMM_W-1:0] w_ext_imm;
    logic             w_ext_err;

    logic             r_out_valid;
    logic [IMM_W-1:0] r_out_imm;
    logic             r_out_err;
    logic             r_skid_valid;
    logic [IMM_W-1:0] r_skid_imm;
    logic             r_skid_err;

    logic             w_in_xfer;
    logic             w_out_free;

    imm_gen_ext u_ext (
        .i_instr (bus.i_instr),
        .i_code  (bus.i_ImmSrc),
        .o_imm   (w_ext_imm),
        .o_err   (w_ext_err)
    );

    assign w_in_xfer  = bus.i_valid && !r_skid_valid;
    assign w_out_free = !r_out_valid || bus.i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst || bus.i_flush) begin
            r_out_valid  <= 1'b0;
            r_out_imm    <= '0;
            r_out_err    <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_imm   <= '0;
            r_skid_err   <= 1'b0;
        end else if (w_out_free) begin
            // A full skid blocks input, so it always refills the output first.
            if (r_skid_valid) begin
                r_out_valid  <= 1'b1;
                r_out_imm    <= r_skid_imm;
                r_out_err    <= r_skid_err;
                r_skid_valid <= 1'b0;
            end else if (w_in_xfer) begin
                r_out_valid <= 1'b1;
                r_out_imm   <= w_ext_imm;
                r_out_err   <= w_ext_err;
            end else begin
                r_out_valid <= 1'b0;
            end
        end else if (w_in_xfer) begin
            r_skid_valid <= 1'b1;
            r_skid_imm   <= w_ext_imm;
            r_skid_err   <= w_ext_err;
        end
    end

    assign bus.o_ready = !r_skid_valid;
    assign bus.o_valid = r_out_valid;
    assign bus.o_imm   = r_out_imm;
    assign bus.o_err   = r_out_err;

endmodule

// File: doc/imm_gen.md
IMM_GEN -- requirements
Module: imm_gen

Interface
REQ-001 SHALL have port i_clk, input, 1: sole clock; all state updates on rising edge.
REQ-002 SHALL have port i_rst, input, 1: reset, synchronous and active-high.
REQ-003 SHALL have port i_flush, input, 1: discard all buffered entries.
REQ-004 SHALL have port i_valid, input, 1: upstream entry valid.
REQ-005 SHALL have port o_ready, output, 1: block can accept an entry this cycle.
REQ-006 SHALL have port i_instr, input, 32: raw instruction word.
REQ-007 SHALL have port i_ImmSrc, input, 3: immediate-format code from the instruction decoder.
REQ-008 SHALL have port o_valid, output, 1: output entry valid.
REQ-009 SHALL have port i_ready, input, 1: downstream accepts the output entry.
REQ-010 SHALL have port o_imm, output, 32: extended immediate.
REQ-011 SHALL have port o_err, output, 1: the entry's code carries no immediate (NO/RT, or reserved code).

Function
REQ-012 SHALL apply format codes NO=0, RT=1, IT=2, ST=3, BT=4, UT=5, JT=6, CZ=7 (CZ only per REQ-030).
REQ-013 SHALL produce IT as {20{instr[31]}, instr[31:20]}.
REQ-014 SHALL produce ST as {20{instr[31]}, instr[31:25], instr[11:7]}.
REQ-015 SHALL produce BT as {19{instr[31]}, instr[31], instr[7], instr[30:25], instr[11:8], 0}.
REQ-016 SHALL produce UT as {instr[31:12], 12'b0}.
REQ-017 SHALL produce JT as {11{instr[31]}, instr[31], instr[19:12], instr[20], instr[30:21], 0}.
REQ-018 SHALL, for NO/RT, produce o_imm=0 with o_err=1; o_err=0 for every valid format.
REQ-019 SHALL transfer an input entry when i_valid && o_ready, and an output entry when o_valid && i_ready.
REQ-020 SHALL present an accepted entry on o_imm/o_err with o_valid=1 exactly one cycle after acceptance when the output stage is empty or draining.
REQ-021 SHALL hold o_valid, o_imm and o_err stable while o_valid && !i_ready.
REQ-022 SHALL hold two entries total: output register plus a skid register; o_ready = skid register empty, registered (no combinational path from i_ready).
REQ-023 SHALL, on accept while the output is stalled, store the entry in the skid register; on the next output transfer, move the skid entry to the output register.
REQ-024 SHALL, on simultaneous input and output transfer with the skid register empty, load the new entry into the output register with no bubble.
REQ-025 SHALL preserve entry order; no entry is dropped or duplicated.
REQ-026 SHALL, on i_flush, clear both entries at the next edge (o_valid=0, o_ready=1), ignoring any same-cycle input entry; i_rst takes priority over i_flush.

Reset
REQ-027 SHALL, on i_rst at a clock edge, set o_valid=0, o_ready=1, o_imm=0, o_err=0, skid register empty.
REQ-028 SHALL discard in-flight entries when reset is asserted mid-stall; the first entry after reset deasserts sees no stale data.

Configuration
REQ-029 SHALL honour macro IMM_GEN_CSR_EN.
REQ-030 SHALL, with IMM_GEN_CSR_EN defined, decode CZ as {27'b0, instr[19:15]} with o_err=0.
REQ-031 SHALL, without IMM_GEN_CSR_EN, treat code 7 as NO: o_imm=0, o_err=1.

Structure
REQ-032 SHALL take format codes NO..JT, CZ from the shared immediate-type constants file used by the instruction decoder; no local redefinition.
REQ-033 SHALL place the combinational format mux in sub-module imm_gen_ext (instr, code -> imm, err); imm_gen owns the handshake and both registers.

Verification
REQ-034 SHALL cover: IT, 0xFFF00093 -> o_imm=0xFFFFFFFF, o_err=0, one cycle later.
REQ-035 SHALL cover: ST 0x0020A423 -> 0x00000008; BT 0xFE000EE3 -> 0xFFFFFFFC; UT 0x123450B7 -> 0x12345000; JT 0x0010006F -> 0x00000800.
REQ-036 SHALL cover: code 7, 0x3002D073 -> 0x00000005/o_err=0 with IMM_GEN_CSR_EN; 0x00000000/o_err=1 without; RT -> 0/o_err=1.
REQ-037 SHALL cover: i_ready=0 for 3 cycles with 3 entries offered -> 2 accepted, o_ready=0, outputs stable; release -> both emerge in order, back-to-back.
REQ-038 SHALL cover: continuous i_valid and i_ready -> one result per cycle, no bubbles.
REQ-039 SHALL cover: i_flush, then i_rst, each with 2 buffered entries -> o_valid=0, o_ready=1 next cycle; new entry emerges next with correct value.
